camera_pattern_gen: RTL

- Synthetic camera source that drives the same pixel-stream interface the camera front-end drives: `hsync`, `vsync`, `validCamera`, `camData`.
- Lets the dHash/movement-detection path run and be verified without a sensor, including deterministic motion via a moving bar.
- CPU configures and controls it through the custom-instruction interface.
- Runs on one clock, replacing `camClock` at the consumer.

---
 rtl/camera_pattern_gen.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen
//   Synthetic camera source. It emits the same framing (vsync, hsync, validCamera, camData)
//   as the sensor front-end, so the dHash/movement path can run without a sensor. The CPU
//   programs it through the custom-instruction port.
//
// Ports
//   clock, reset             sole clock, synchronous active-high reset
//   ciStart, ciN             instruction strobe and number (matched against customId)
//   ciValueA[2:0]            command: 0 status, 1 geometry, 2 pattern, 3 control, 4-7 no-op
//   ciValueB                 command data
//   ciResult, ciDone         status word and one-cycle completion pulse (registered)
//   vsync, hsync             frame / line framing strobes (registered)
//   validCamera, camData     pixel qualifier and pixel value (registered, data 0 when idle)
module camera_pattern_gen #(
  parameter logic [7:0]  customId     = 8'd0,
  parameter int unsigned vsyncCycles  = 4,
  parameter int unsigned hsyncCycles  = 2,
  parameter int unsigned hblankCycles = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        vsync,
  output logic        hsync,
  output logic        validCamera,
  output logic [7:0]  camData
);

  localparam logic [15:0] VsyncLast  = 16'(vsyncCycles - 1);
  localparam logic [15:0] HsyncLast  = 16'(hsyncCycles - 1);
  localparam logic [15:0] HblankLast = 16'(hblankCycles - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StHsync, StActive, StHblank} state_e;

  state_e      state;
  logic [15:0] phaseCnt;
  logic [10:0] row;
  logic [10:0] column;
  logic        running;
  logic        singleShot;
  logic        stopPending;
  logic [15:0] frameCount;
  logic [10:0] barPos;
  logic        barClearPending;
  logic [15:0] lfsr;

  // Active configuration, frozen for the duration of a frame.
  logic [10:0] width;
  logic [10:0] height;
  logic [1:0]  mode;
  logic [7:0]  level;
  logic [7:0]  barWidth;

  // Shadow configuration written by the CPU. Step is only consumed at frame entry, exactly
  // when the shadows become active, so it needs no active copy.
  logic [10:0] widthShadow;
  logic [10:0] heightShadow;
  logic [1:0]  modeShadow;
  logic [7:0]  levelShadow;
  logic [7:0]  stepShadow;
  logic [7:0]  barWidthShadow;

  logic        validInstr;
  logic [2:0]  cmdSel;
  logic [31:0] statusWord;
  logic        startCmd;
  logic        stopCmd;
  logic        frameEnd;
  logic        continueRun;
  logic        frameRestart;
  logic        loadShadow;
  logic [10:0] pixCol;
  logic [11:0] barEnd;
  logic [7:0]  pixel;
  logic [15:0] lfsrNext;
  logic [11:0] barSum;
  logic [11:0] barWrap;
  logic [10:0] barAdvanced;
  logic [10:0] geomWidth;
  logic [10:0] geomHeight;
  logic        unusedCiBits;

  assign unusedCiBits = ^{ciValueA[31:3], ciValueB[7:2]};

  always_comb begin
    validInstr  = ciStart && (ciN == customId);
    cmdSel      = ciValueA[2:0];
    statusWord  = {frameCount, 14'b0, singleShot, running};
    startCmd    = validInstr && (cmdSel == 3'd3) && ciValueB[0] && !running;
    stopCmd     = validInstr && (cmdSel == 3'd3) && !ciValueB[0] && running;
    frameEnd    = (state == StHblank) && (phaseCnt == HblankLast) &&
                  (row == height - 11'd1);
    // A stop issued in the very cycle the frame completes is honoured immediately.
    continueRun  = running && !singleShot && !stopPending && !stopCmd;
    frameRestart = frameEnd && continueRun;
    loadShadow   = ((state == StIdle) && startCmd) || frameRestart;

    geomWidth  = (ciValueB[10:0] == 11'd0) ? 11'd1 : ciValueB[10:0];
    geomHeight = (ciValueB[26:16] == 11'd0) ? 11'd1 : ciValueB[26:16];

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    lfsrNext = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // Pixel loaded into camData this cycle: column 0 when leaving HSYNC, else the next column.
    pixCol = (state == StActive) ? column + 11'd1 : 11'd0;
    barEnd = {1'b0, barPos} + {4'b0, barWidth};
    case (mode)
      2'd0:    pixel = level;
      2'd1:    pixel = pixCol[7:0];
      2'd2:    pixel = (({1'b0, pixCol} >= {1'b0, barPos}) && ({1'b0, pixCol} < barEnd)) ?
                       8'hFF : 8'h00;
      default: pixel = lfsr[7:0];
    endcase

    // Bar advance uses the geometry of the frame about to start.
    barSum  = {1'b0, barPos} + {4'b0, stepShadow};
    barWrap = barSum - {1'b0, widthShadow};
    if (barSum < {1'b0, widthShadow}) begin
      barAdvanced = barSum[10:0];
    end else if (barWrap < {1'b0, widthShadow}) begin
      barAdvanced = barWrap[10:0];
    end else begin
      barAdvanced = 11'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= StIdle;
      phaseCnt        <= 16'd0;
      row             <= 11'd0;
      column          <= 11'd0;
      running         <= 1'b0;
      singleShot      <= 1'b0;
      stopPending     <= 1'b0;
      frameCount      <= 16'd0;
      barPos          <= 11'd0;
      barClearPending <= 1'b0;
      lfsr            <= 16'hACE1;
      width           <= 11'd640;
      height          <= 11'd480;
      mode            <= 2'd0;
      level           <= 8'h80;
      barWidth        <= 8'd0;
      widthShadow     <= 11'd640;
      heightShadow    <= 11'd480;
      modeShadow      <= 2'd0;
      levelShadow     <= 8'h80;
      stepShadow      <= 8'd0;
      barWidthShadow  <= 8'd0;
      ciDone          <= 1'b0;
      ciResult        <= 32'd0;
      vsync           <= 1'b0;
      hsync           <= 1'b0;
      validCamera     <= 1'b0;
      camData         <= 8'd0;
    end else begin
      ciDone   <= validInstr;
      ciResult <= validInstr ? statusWord : 32'd0;

      case (state)
        StIdle: begin
          vsync       <= 1'b0;
          hsync       <= 1'b0;
          validCamera <= 1'b0;
          camData     <= 8'd0;
          if (startCmd) begin
            state    <= StVsync;
            vsync    <= 1'b1;
            phaseCnt <= 16'd0;
          end
        end
        StVsync: begin
          if (phaseCnt == VsyncLast) begin
            state    <= StHsync;
            vsync    <= 1'b0;
            hsync    <= 1'b1;
            phaseCnt <= 16'd0;
            row      <= 11'd0;
          end else begin
            phaseCnt <= phaseCnt + 16'd1;
          end
        end
        StHsync: begin
          if (phaseCnt == HsyncLast) begin
            state       <= StActive;
            hsync       <= 1'b0;
            validCamera <= 1'b1;
            camData     <= pixel;
            lfsr        <= lfsrNext;
            column      <= 11'd0;
          end else begin
            phaseCnt <= phaseCnt + 16'd1;
          end
        end
        StActive: begin
          if (column == width - 11'd1) begin
            state       <= StHblank;
            validCamera <= 1'b0;
            camData     <= 8'd0;
            phaseCnt    <= 16'd0;
          end else begin
            column  <= column + 11'd1;
            camData <= pixel;
            lfsr    <= lfsrNext;
          end
        end
        StHblank: begin
          if (phaseCnt == HblankLast) begin
            phaseCnt <= 16'd0;
            if (!frameEnd) begin
              state <= StHsync;
              hsync <= 1'b1;
              row   <= row + 11'd1;
            end else begin
              frameCount <= frameCount + 16'd1;
              if (continueRun) begin
                state <= StVsync;
                vsync <= 1'b1;
              end else begin
                state       <= StIdle;
                running     <= 1'b0;
                singleShot  <= 1'b0;
                stopPending <= 1'b0;
              end
            end
          end else begin
            phaseCnt <= phaseCnt + 16'd1;
          end
        end
        default: state <= StIdle;
      endcase

      // Entry to VSYNC: adopt the shadow configuration and position the bar.
      if (loadShadow) begin
        width    <= widthShadow;
        height   <= heightShadow;
        mode     <= modeShadow;
        level    <= levelShadow;
        barWidth <= barWidthShadow;
        if (barClearPending) begin
          barPos <= 11'd0;
        end else if (frameRestart) begin
          barPos <= barAdvanced;
        end
        barClearPending <= 1'b0;
      end

      // CPU commands; placed last so a pattern write overrides a same-cycle bar update.
      if (validInstr) begin
        case (cmdSel)
          3'd1: begin
            widthShadow  <= geomWidth;
            heightShadow <= geomHeight;
          end
          3'd2: begin
            modeShadow     <= ciValueB[1:0];
            levelShadow    <= ciValueB[15:8];
            stepShadow     <= ciValueB[23:16];
            barWidthShadow <= ciValueB[31:24];
            // Defer the bar reset to the next frame boundary while a frame is on screen.
            if (running) begin
              barClearPending <= 1'b1;
            end else begin
              barPos <= 11'd0;
            end
          end
          3'd3: begin
            if (startCmd) begin
              running     <= 1'b1;
              singleShot  <= ciValueB[1];
              stopPending <= 1'b0;
            end
            if (stopCmd) begin
              stopPending <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
